// File: rtl/encap_packet.sv
// rtl/encap_packet.sv - serialises one DFX word into a train of 64-bit Aurora frames
// Each frame is {payload[54:0], frame_cnt[4:0], SOF, EOF, 2'b00}; the data output is registered.
module encap_packet #(
  parameter int DATA_WIDTH        = 1024,
  parameter int ADDR_WIDTH        = 10,
  parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int PAYLOAD_BITS      = 55
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_DFX_WIDTH-1:0]    data_dfx_in,
  input  logic                         valid_dfx_in,
  output logic                         ready_dfx_in,
  output logic [AURORA_DATA_WIDTH-1:0] data_out_dfx,
  output logic                         valid_out_dfx,
  input  logic                         tx_ready,
  output logic                         busy_encap_pkt,
  output logic                         done_encap_pkt
);

  localparam int NUM_FRAMES = (DATA_DFX_WIDTH + PAYLOAD_BITS - 1) / PAYLOAD_BITS;
  localparam int PAD_WIDTH  = NUM_FRAMES * PAYLOAD_BITS;
  localparam int PAD_BITS   = PAD_WIDTH - DATA_DFX_WIDTH;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(NUM_FRAMES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                   r_state;
  logic [DATA_DFX_WIDTH-1:0]    r_word;
  logic [CNT_W-1:0]             r_frame_cnt;
  logic [AURORA_DATA_WIDTH-1:0] r_data_out;
  logic                         r_done;

  logic [PAD_WIDTH-1:0]         w_word_pad;
  logic [PAD_WIDTH-1:0]         w_in_pad;
  logic [CNT_W-1:0]             w_next_cnt;

  // Zero-extending the word makes the short last frame's unused payload bits zero for free.
  assign w_word_pad = {{PAD_BITS{1'b0}}, r_word};
  assign w_in_pad   = {{PAD_BITS{1'b0}}, data_dfx_in};
  assign w_next_cnt = r_frame_cnt + CNT_W'(1);

  function automatic logic [AURORA_DATA_WIDTH-1:0] build_frame(
    input logic [PAD_WIDTH-1:0] pw,
    input logic [CNT_W-1:0]     k
  );
    logic [PAYLOAD_BITS-1:0] w_pl;
    w_pl = pw[int'(k) * PAYLOAD_BITS +: PAYLOAD_BITS];
    return {w_pl, k, (k == '0), (k == LAST_FRAME), 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_word      <= '0;
      r_frame_cnt <= '0;
      r_data_out  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_dfx_in) begin
            r_word      <= data_dfx_in;
            r_frame_cnt <= '0;
            r_data_out  <= build_frame(w_in_pad, '0);
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (r_frame_cnt == LAST_FRAME) begin
              r_state     <= IDLE;
              r_frame_cnt <= '0;
              r_data_out  <= '0;
              r_done      <= 1'b1;
            end else begin
              r_frame_cnt <= w_next_cnt;
              r_data_out  <= build_frame(w_word_pad, w_next_cnt);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_dfx_in   = (r_state == IDLE);
  assign valid_out_dfx  = (r_state == SEND);
  assign busy_encap_pkt = (r_state == SEND);
  assign done_encap_pkt = r_done;
  assign data_out_dfx   = r_data_out;

endmodule

// File: doc/encap_packet.md
# encap_packet

Transmit-side counterpart of the output-port packet decapsulator. Accepts one DATA_DFX_WIDTH-bit DFX word (payload plus address) and serialises it into NUM_FRAMES 64-bit Aurora frames. Each frame carries up to 55 payload bits in [63:9] and a 9-bit frame header in [8:0]. It sits between the DFX source and the Aurora TX stream, with ready/valid flow control on both sides.

## Interface
- DATA_WIDTH, 1024, payload bits of a DFX word
- ADDR_WIDTH, 10, address bits appended above the payload
- DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH (1034), packed DFX word width
- AURORA_DATA_WIDTH, 64, frame width
- PAYLOAD_BITS, 55, payload bits per frame, in [63:9]
- NUM_FRAMES, 19, frames per packet: ceil(1034/55); the last frame carries 44 bits

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  reset, synchronous and active-high
- data_dfx_in  in  DATA_DFX_WIDTH  DFX word; the address occupies [1033:1024]
- valid_dfx_in  in  1  data_dfx_in is valid
- ready_dfx_in  out  1  block can accept a word
- data_out_dfx  out  AURORA_DATA_WIDTH  current frame
- valid_out_dfx  out  1  data_out_dfx is valid
- tx_ready  in  1  Aurora TX accepts the frame this cycle
- busy_encap_pkt  out  1  a packet is in flight
- done_encap_pkt  out  1  one-cycle pulse after the last frame transfers

## Operation
- States: IDLE, SEND.
- IDLE:
  - ready_dfx_in=1, valid_out_dfx=0.
  - On valid_dfx_in, capture data_dfx_in into a shift/hold register, clear frame_cnt to 0, and go to SEND.
- SEND:
  - ready_dfx_in=0, valid_out_dfx=1, busy_encap_pkt=1.
  - data_out_dfx is a registered output and is stable while tx_ready=0.
- Frame k (k=0..17):
  - [63:9] = word[k*55 +: 55].
- Frame 18:
  - [63:53] = 0.
  - [52:9] = word[1033:990].
- Header [8:0]:
  - [8:4] = frame_cnt (0..18).
  - [3] = SOF (k==0).
  - [2] = EOF (k==18).
  - [1:0] = 2'b00.
- Transfer occurs when valid_out_dfx && tx_ready. On a transfer with k<18, frame_cnt increments.
- On the transfer with k==18:
  - done_encap_pkt pulses for 1 cycle on the next edge.
  - State returns to IDLE.
  - frame_cnt clears to 0.
- frame_cnt never exceeds 18. It has no wrap path other than the EOF transfer.
- Input words presented while in SEND are ignored, because ready_dfx_in=0. The source must hold a word until it sees ready_dfx_in.
- Unused payload bits of frame 18 ([63:53]) are always zero, regardless of the input.

## Timing
- Reset values:
  - ready_dfx_in=1 (IDLE), valid_out_dfx=0, data_out_dfx=0, busy_encap_pkt=0, done_encap_pkt=0, frame_cnt=0.
- Reset mid-packet: the next edge forces IDLE and all outputs to reset values. The partial packet is dropped, no EOF is sent and no done pulse is produced.
- Latency: a word accepted at edge N has frame 0 valid from edge N+1.
- With tx_ready held high, frames 0..18 occupy cycles N+1..N+19. done_encap_pkt is high in cycle N+20, and ready_dfx_in is high again in cycle N+20.
- A minimum period of 20 cycles per packet applies: 19 frames plus 1 idle/accept cycle.
- tx_ready low stalls the current frame with no data change and no count change. tx_ready may toggle every cycle.
- done_encap_pkt and ready_dfx_in rise in the same cycle. A word presented in that cycle is accepted, and frame 0 of the new packet follows on the next edge.

## Test plan
- **Reset defaults:** assert rst for 2 cycles, then deassert -> all outputs at their reset values and ready_dfx_in=1.
- **Single packet, tx_ready=1:**
  - Stimulus: word with word[i]=i[0] (alternating), address 10'h3A5.
  - Response: 19 consecutive frames; frame 0 header = 9'b00000_1000; frame 18 header = 9'b10010_0100.
  - Frame 18 [63:53]=0 and [52:43] = 10'h3A5.
  - done_encap_pkt pulses at cycle 20.
- **Backpressure:** tx_ready pattern 1,0,0,1 repeating -> each frame held unchanged while stalled, no frame skipped or duplicated, and 19 transfers total.
- **Back-to-back packets:**
  - Stimulus: valid_dfx_in held high with two words, all-ones then all-zeros.
  - Response: the second word is accepted in the done cycle. Its frames carry all-zero payload with correct headers, and the first packet's frame 18 [63:53] is zero even with an all-ones input.
- **Input during SEND:** change data_dfx_in mid-packet -> transmitted frames unchanged, and the new word is accepted only after done.
- **Reset mid-packet:** assert rst after frame 7 transfers -> outputs return to reset values next cycle, and a following packet starts at frame_cnt=0 with SOF=1.
